// File: rtl/ide_pkg.sv
// Shared constants and state encodings for the IDE sector controller.
// Task-file register map, command codes, status bit positions and FSM states.
package ide_pkg;

    localparam logic [2:0] IDE_REG_DATA  = 3'd0;
    localparam logic [2:0] IDE_REG_COUNT = 3'd2;
    localparam logic [2:0] IDE_REG_LBA0  = 3'd3;
    localparam logic [2:0] IDE_REG_LBA1  = 3'd4;
    localparam logic [2:0] IDE_REG_LBA2  = 3'd5;
    localparam logic [2:0] IDE_REG_CMD   = 3'd7;

    localparam logic [7:0] IDE_CMD_READ  = 8'h20;
    localparam logic [7:0] IDE_CMD_WRITE = 8'h30;

    localparam int unsigned IDE_ST_BSY = 7;
    localparam int unsigned IDE_ST_DRQ = 3;
    localparam int unsigned IDE_ST_ERR = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET_CNT,
        ST_SET_LBA0,
        ST_SET_LBA1,
        ST_SET_LBA2,
        ST_SET_CMD,
        ST_POLL,
        ST_XFER,
        ST_FINISH,
        ST_ERROR
    } ctrl_state_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_STROBE,
        BUS_HOLD
    } bus_phase_e;

endpackage

// File: rtl/ide_bus_cycle.sv
// One IDE task-file access: SETUP, STROBE_CYCLES of oe_n/we_n low, HOLD.
// Address, write data and direction are latched at start and held for the access.
module ide_bus_cycle
    import ide_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       start,
    input  logic       rw,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       last,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       ide_ce_n,
    output logic       ide_oe_n,
    output logic       ide_we_n,
    output logic [2:0] ide_addr,
    output logic [7:0] ide_wdata,
    output logic       ide_wdata_oe,
    input  logic [7:0] ide_rdata
);

    localparam int unsigned SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    bus_phase_e phase_q, phase_d;
    logic [SW-1:0] strb_cnt_q, strb_cnt_d;
    logic rw_q, rw_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic rdata_valid_q, rdata_valid_d;

    always_comb begin
        phase_d       = phase_q;
        strb_cnt_d    = strb_cnt_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        case (phase_q)
            BUS_IDLE: begin
                if (start) begin
                    phase_d = BUS_SETUP;
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            BUS_SETUP: begin
                phase_d    = BUS_STROBE;
                strb_cnt_d = '0;
            end
            BUS_STROBE: begin
                if (strb_cnt_q == SW'(STROBE_CYCLES - 1)) begin
                    phase_d = BUS_HOLD;
                    if (!rw_q) begin
                        rdata_d       = ide_rdata;
                        rdata_valid_d = 1'b1;
                    end
                end else begin
                    strb_cnt_d = strb_cnt_q + 1'b1;
                end
            end
            BUS_HOLD: phase_d = BUS_IDLE;
            default:  phase_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            phase_q       <= BUS_IDLE;
            strb_cnt_q    <= '0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            strb_cnt_q    <= strb_cnt_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign busy         = (phase_q != BUS_IDLE);
    assign last         = (phase_q == BUS_HOLD);
    assign rdata        = rdata_q;
    assign rdata_valid  = rdata_valid_q;
    assign ide_ce_n     = (phase_q == BUS_IDLE);
    assign ide_oe_n     = !((phase_q == BUS_STROBE) && !rw_q);
    assign ide_we_n     = !((phase_q == BUS_STROBE) && rw_q);
    assign ide_addr     = addr_q;
    assign ide_wdata    = wdata_q;
    assign ide_wdata_oe = rw_q && (phase_q != BUS_IDLE);

endmodule

// File: rtl/ide_sector_ctrl.sv
// Single-sector LBA read/write sequencer for the 8-bit IDE task-file bus.
// Programs count/LBA/command, polls status, then streams SECTOR_BYTES data bytes.
module ide_sector_ctrl
    import ide_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned POLL_TIMEOUT  = 1024,
    parameter int unsigned SECTOR_BYTES  = 512
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [23:0] cmd_lba,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        done,
    output logic        error,
    output logic        ide_ce_n,
    output logic        ide_oe_n,
    output logic        ide_we_n,
    output logic [2:0]  ide_addr,
    output logic [7:0]  ide_wdata,
    output logic        ide_wdata_oe,
    input  logic [7:0]  ide_rdata
);

    localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);
    localparam int unsigned CW = $clog2(SECTOR_BYTES) + 1;

    ctrl_state_e state_q, state_d;
    logic          write_q, write_d;
    logic [23:0]   lba_q, lba_d;
    logic          error_q, error_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;

    logic       bus_start, bus_rw, bus_busy, bus_last, bus_rdata_valid;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;

    assign wr_ready = (state_q == ST_XFER) && write_q && !bus_busy;

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        lba_d      = lba_q;
        error_d    = error_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        byte_cnt_d = byte_cnt_q;
        poll_cnt_d = poll_cnt_q;
        bus_start  = 1'b0;
        bus_rw     = 1'b1;
        bus_addr   = IDE_REG_DATA;
        bus_wdata  = '0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    write_d    = cmd_write;
                    lba_d      = cmd_lba;
                    error_d    = 1'b0;
                    byte_cnt_d = '0;
                    poll_cnt_d = '0;
                    state_d    = ST_SET_CNT;
                end
            end
            ST_SET_CNT: begin
                bus_addr  = IDE_REG_COUNT;
                bus_wdata = 8'h01;
                bus_start = !bus_busy;
                if (bus_last) state_d = ST_SET_LBA0;
            end
            ST_SET_LBA0: begin
                bus_addr  = IDE_REG_LBA0;
                bus_wdata = lba_q[7:0];
                bus_start = !bus_busy;
                if (bus_last) state_d = ST_SET_LBA1;
            end
            ST_SET_LBA1: begin
                bus_addr  = IDE_REG_LBA1;
                bus_wdata = lba_q[15:8];
                bus_start = !bus_busy;
                if (bus_last) state_d = ST_SET_LBA2;
            end
            ST_SET_LBA2: begin
                bus_addr  = IDE_REG_LBA2;
                bus_wdata = lba_q[23:16];
                bus_start = !bus_busy;
                if (bus_last) state_d = ST_SET_CMD;
            end
            ST_SET_CMD: begin
                bus_addr  = IDE_REG_CMD;
                bus_wdata = write_q ? IDE_CMD_WRITE : IDE_CMD_READ;
                bus_start = !bus_busy;
                if (bus_last) state_d = ST_POLL;
            end
            ST_POLL: begin
                bus_rw    = 1'b0;
                bus_addr  = IDE_REG_CMD;
                bus_start = !bus_busy;
                // ERR wins over DRQ; the timeout is checked only on failed polls
                if (bus_rdata_valid) begin
                    if (bus_rdata[IDE_ST_ERR]) begin
                        error_d = 1'b1;
                        state_d = ST_ERROR;
                    end else if (!bus_rdata[IDE_ST_BSY] && bus_rdata[IDE_ST_DRQ]) begin
                        state_d = ST_XFER;
                    end else if (poll_cnt_q == PW'(POLL_TIMEOUT - 1)) begin
                        error_d = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                    end
                end
            end
            ST_XFER: begin
                bus_addr = IDE_REG_DATA;
                if (write_q) begin
                    bus_wdata = wr_data;
                    bus_start = wr_valid && wr_ready;
                    if (bus_last) begin
                        if (byte_cnt_q == CW'(SECTOR_BYTES - 1)) state_d = ST_FINISH;
                        else byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else begin
                    bus_rw    = 1'b0;
                    bus_start = !bus_busy && !rd_valid_q;
                    if (bus_rdata_valid) begin
                        rd_data_d  = bus_rdata;
                        rd_valid_d = 1'b1;
                    end
                    if (rd_valid_q && rd_ready) begin
                        rd_valid_d = 1'b0;
                        if (byte_cnt_q == CW'(SECTOR_BYTES - 1)) state_d = ST_FINISH;
                        else byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                done       = 1'b1;
                rd_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
            ST_ERROR: begin
                done       = 1'b1;
                rd_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            lba_q      <= '0;
            error_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            byte_cnt_q <= '0;
            poll_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            lba_q      <= lba_d;
            error_q    <= error_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            byte_cnt_q <= byte_cnt_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign error     = error_q;

    ide_bus_cycle #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
        .clk          (clk),
        .arst         (arst),
        .start        (bus_start),
        .rw           (bus_rw),
        .addr         (bus_addr),
        .wdata        (bus_wdata),
        .busy         (bus_busy),
        .last         (bus_last),
        .rdata        (bus_rdata),
        .rdata_valid  (bus_rdata_valid),
        .ide_ce_n     (ide_ce_n),
        .ide_oe_n     (ide_oe_n),
        .ide_we_n     (ide_we_n),
        .ide_addr     (ide_addr),
        .ide_wdata    (ide_wdata),
        .ide_wdata_oe (ide_wdata_oe),
        .ide_rdata    (ide_rdata)
    );

endmodule

// File: tb/tb_ide_sector_ctrl.sv
// Self-checking bench for ide_sector_ctrl with a behavioural task-file drive model.
// Table of command scenarios plus hand-written back-pressure and mid-transfer reset sequences.
module tb_ide_sector_ctrl;

    localparam int PT = 8;

    logic        clk = 1'b0;
    logic        arst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [23:0] cmd_lba;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_ready;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready;
    logic        done, error;
    logic        ide_ce_n, ide_oe_n, ide_we_n;
    logic [2:0]  ide_addr;
    logic [7:0]  ide_wdata;
    logic        ide_wdata_oe;
    logic [7:0]  ide_rdata;

    always #5 clk = ~clk;

    ide_sector_ctrl #(.STROBE_CYCLES(2), .POLL_TIMEOUT(PT), .SECTOR_BYTES(512)) dut (
        .clk(clk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_lba(cmd_lba),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .done(done), .error(error),
        .ide_ce_n(ide_ce_n), .ide_oe_n(ide_oe_n), .ide_we_n(ide_we_n),
        .ide_addr(ide_addr), .ide_wdata(ide_wdata), .ide_wdata_oe(ide_wdata_oe),
        .ide_rdata(ide_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- drive model ----------------
    logic [7:0]  mem [0:2047];
    logic [2:0]  log_addr [$];
    logic [7:0]  log_data [$];
    logic [23:0] d_lba = '0;
    int          ptr = 0;
    int          busy_polls = 0;
    logic        force_en = 1'b0;
    logic [7:0]  stat_force = 8'h00;
    int          stat_reads = 0, data_reads = 0, data_writes = 0;
    int          viol = 0, activity = 0;
    int          oe_len = 0, we_len = 0;
    logic        prev_oe = 1'b1, we_done = 1'b0;

    always_comb begin
        ide_rdata = 8'h00;
        if (ide_addr == 3'd7)      ide_rdata = force_en ? stat_force : (busy_polls > 0 ? 8'h80 : 8'h08);
        else if (ide_addr == 3'd0) ide_rdata = mem[ptr[10:0]];
    end

    always @(posedge clk) begin
        if (!ide_ce_n) activity++;
        if (!ide_oe_n && !ide_we_n) viol++;
        if (!ide_we_n && !ide_wdata_oe) viol++;
        if (!ide_oe_n && ide_wdata_oe) viol++;
        if ((!ide_oe_n || !ide_we_n) && ide_ce_n) viol++;
        if (arst) begin
            oe_len = 0;
            we_len = 0;
        end else begin
            if (!ide_oe_n) oe_len++;
            else begin if (oe_len != 0 && oe_len != 2) viol++; oe_len = 0; end
            if (!ide_we_n) we_len++;
            else begin if (we_len != 0 && we_len != 2) viol++; we_len = 0; end
        end
        if (!ide_we_n && !we_done) begin
            we_done = 1'b1;
            if (ide_addr == 3'd0) begin
                mem[ptr[10:0]] = ide_wdata;
                ptr++;
                data_writes++;
            end else begin
                log_addr.push_back(ide_addr);
                log_data.push_back(ide_wdata);
                case (ide_addr)
                    3'd3: d_lba[7:0]   = ide_wdata;
                    3'd4: d_lba[15:8]  = ide_wdata;
                    3'd5: d_lba[23:16] = ide_wdata;
                    3'd7: begin ptr = int'(d_lba); busy_polls = 2; end
                    default: ;
                endcase
            end
        end
        if (ide_we_n) we_done = 1'b0;
        if (!prev_oe && ide_oe_n) begin
            if (ide_addr == 3'd7) begin
                stat_reads++;
                if (busy_polls > 0) busy_polls--;
            end else if (ide_addr == 3'd0) begin
                ptr++;
                data_reads++;
            end
        end
        prev_oe = ide_oe_n;
    end

    task automatic clear_model();
        log_addr.delete();
        log_data.delete();
        stat_reads  = 0;
        data_reads  = 0;
        data_writes = 0;
    endtask

    // ---------------- command driver / consumer ----------------
    task automatic run_cmd(input logic wr, input logic [23:0] lba, input int stall_at, input int reset_at,
                           output int done_cnt, output logic err_at_done, output int rd_cnt,
                           output int rd_bad, output int wr_cnt, output int stall_bad, output logic timed_out);
        int wr_idx = 0;
        logic hs = 1'b0;
        int stall_left = 20;
        logic [7:0] held = '0;
        logic holding = 1'b0;
        int after = -1;
        done_cnt = 0; err_at_done = 1'b0; rd_cnt = 0; rd_bad = 0; wr_cnt = 0; stall_bad = 0; timed_out = 1'b0;
        @(negedge clk);
        cmd_write = wr; cmd_lba = lba; cmd_valid = 1'b1; rd_ready = 1'b1;
        wr_valid = wr; wr_data = 8'hA5;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (reset_at >= 0 && rd_cnt == reset_at) return;
            if (hs) begin wr_idx++; wr_cnt++; end
            wr_data = 8'hA5 ^ wr_idx[7:0];
            hs = wr_valid && wr_ready;
            if (stall_at >= 0 && rd_cnt == stall_at && stall_left > 0) begin
                rd_ready = 1'b0;
                stall_left--;
            end else rd_ready = 1'b1;
            if (rd_valid && rd_ready) begin
                if (rd_data !== rd_cnt[7:0]) rd_bad++;
                rd_cnt++;
                holding = 1'b0;
            end else if (rd_valid) begin
                if (holding && rd_data !== held) stall_bad++;
                if (!ide_ce_n) stall_bad++;
                held = rd_data;
                holding = 1'b1;
            end
            if (done) begin
                done_cnt++;
                err_at_done = error;
                if (after < 0) after = c;
            end
            if (after >= 0 && c >= after + 4) break;
            @(negedge clk);
        end
        timed_out = (after < 0);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
    endtask

    typedef struct {
        logic        wr;
        logic [23:0] lba;
        logic        force_en;
        logic [7:0]  stat;
        logic        exp_err;
        int          exp_stat_reads;
        int          exp_data;
    } scen_t;

    scen_t tbl [7];

    initial begin
        int dc, rc, rb, wc, sb, bad;
        logic ea, to;
        logic [7:0] exp_reg [5];
        logic [2:0] exp_adr [5];

        tbl[0] = '{1'b0, 24'h000010, 1'b0, 8'h00, 1'b0, 3,  512};
        tbl[1] = '{1'b1, 24'h000200, 1'b0, 8'h00, 1'b0, 3,  512};
        tbl[2] = '{1'b0, 24'h000010, 1'b1, 8'h80, 1'b1, PT, 0};
        tbl[3] = '{1'b0, 24'h000010, 1'b1, 8'h01, 1'b1, 1,  0};
        tbl[4] = '{1'b0, 24'h000010, 1'b0, 8'h00, 1'b0, 3,  512};
        tbl[5] = '{1'b1, 24'h000200, 1'b1, 8'h09, 1'b1, 1,  0};
        tbl[6] = '{1'b0, 24'h000010, 1'b1, 8'h88, 1'b1, PT, 0};

        arst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_lba = '0;
        rd_ready = 1'b1; wr_data = '0; wr_valid = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_strobes", {ide_ce_n, ide_oe_n, ide_we_n}, 3'b111);
        chk("rst_addr_wdata", {ide_addr, ide_wdata, ide_wdata_oe}, 12'h000);

        for (int s = 0; s < 7; s++) begin
            clear_model();
            force_en = tbl[s].force_en;
            stat_force = tbl[s].stat;
            if (!tbl[s].wr) for (int i = 0; i < 512; i++) mem[int'(tbl[s].lba) + i] = 8'(i);
            chk($sformatf("s%0d_cmd_ready", s), cmd_ready, 1);
            run_cmd(tbl[s].wr, tbl[s].lba, -1, -1, dc, ea, rc, rb, wc, sb, to);
            chk($sformatf("s%0d_timeout", s), to, 0);
            chk($sformatf("s%0d_done_pulses", s), dc, 1);
            chk($sformatf("s%0d_error", s), ea, tbl[s].exp_err);
            chk($sformatf("s%0d_error_sticky", s), error, tbl[s].exp_err);
            chk($sformatf("s%0d_status_reads", s), stat_reads, tbl[s].exp_stat_reads);
            exp_adr = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
            exp_reg = '{8'h01, tbl[s].lba[7:0], tbl[s].lba[15:8], tbl[s].lba[23:16],
                        tbl[s].wr ? 8'h30 : 8'h20};
            chk($sformatf("s%0d_reg_writes", s), log_addr.size(), 5);
            for (int k = 0; k < 5 && k < log_addr.size(); k++)
                chk($sformatf("s%0d_reg%0d", s, k), {log_addr[k], log_data[k]}, {exp_adr[k], exp_reg[k]});
            if (tbl[s].wr) begin
                chk($sformatf("s%0d_data_writes", s), data_writes, tbl[s].exp_data);
                chk($sformatf("s%0d_wr_handshakes", s), wc, tbl[s].exp_data);
                chk($sformatf("s%0d_data_reads", s), data_reads, 0);
                bad = 0;
                for (int i = 0; i < tbl[s].exp_data; i++)
                    if (mem[int'(tbl[s].lba) + i] !== (8'hA5 ^ 8'(i))) bad++;
                chk($sformatf("s%0d_mem_bad", s), bad, 0);
            end else begin
                chk($sformatf("s%0d_data_reads", s), data_reads, tbl[s].exp_data);
                chk($sformatf("s%0d_rd_bytes", s), rc, tbl[s].exp_data);
                chk($sformatf("s%0d_rd_bad", s), rb, 0);
                chk($sformatf("s%0d_data_writes", s), data_writes, 0);
            end
        end

        // back-pressure at byte 5
        clear_model();
        force_en = 1'b0;
        for (int i = 0; i < 512; i++) mem[16 + i] = 8'(i);
        run_cmd(1'b0, 24'h000010, 5, -1, dc, ea, rc, rb, wc, sb, to);
        chk("stall_timeout", to, 0);
        chk("stall_done", dc, 1);
        chk("stall_error", ea, 0);
        chk("stall_bytes", rc, 512);
        chk("stall_rd_bad", rb, 0);
        chk("stall_hold_bad", sb, 0);
        chk("stall_data_reads", data_reads, 512);

        chk("protocol_violations", viol, 0);

        // reset while streaming byte 100
        clear_model();
        run_cmd(1'b0, 24'h000010, -1, 100, dc, ea, rc, rb, wc, sb, to);
        chk("rstx_reached", rc, 100);
        arst = 1'b1;
        #1;
        chk("rstx_strobes", {ide_ce_n, ide_oe_n, ide_we_n}, 3'b111);
        chk("rstx_cmd_ready", cmd_ready, 1);
        chk("rstx_error", error, 0);
        chk("rstx_rd_valid", rd_valid, 0);
        @(negedge clk);
        arst = 1'b0;
        begin
            int act0;
            act0 = activity;
            repeat (50) @(negedge clk);
            chk("rstx_no_activity", activity, act0);
        end
        chk("rstx_idle", cmd_ready, 1);
        chk("rstx_done_low", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ide_sector_ctrl.md
Name: ide_sector_ctrl

Overview:
Host-side controller that sequences the 8-bit IDE task-file bus for single-sector (512-byte) LBA reads and writes. Accepts one command at a time from the CPU-side command port. Issues the register writes (sector count, LBA0..2, command), polls status, then streams data bytes between the drive data register and valid/ready byte ports. Sits between the CPU bus glue and the ide_drive bus pins (ce_n/oe_n/we_n/address/data).

Parameters:
STROBE_CYCLES, 2, cycles oe_n/we_n held low per bus access (min 1)
POLL_TIMEOUT, 1024, max status polls before timeout error
SECTOR_BYTES, 512, bytes per sector transfer

Ports:
clk  in  1  system clock
arst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  controller idle, command accepted when valid&ready
cmd_write  in  1  1=write sector (0x30), 0=read sector (0x20)
cmd_lba  in  24  sector LBA {LBA2,LBA1,LBA0}
rd_data  out  8  byte read from drive
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts rd_data
wr_data  in  8  byte to write to drive
wr_valid  in  1  wr_data valid
wr_ready  out  1  controller takes wr_data
done  out  1  one-cycle pulse, command finished (with or without error)
error  out  1  sticky error flag, cleared on next accepted command
ide_ce_n  out  1  drive chip enable, active-low
ide_oe_n  out  1  drive output enable, active-low
ide_we_n  out  1  drive write enable, active-low
ide_addr  out  3  task-file register address
ide_wdata  out  8  data toward drive
ide_wdata_oe  out  1  drive ide_wdata onto bus (high only during write accesses)
ide_rdata  in  8  data from drive

Behaviour:
- Reset (arst high, async): state IDLE; cmd_ready=1; rd_valid=0, wr_ready=0, done=0, error=0; ide_ce_n=ide_oe_n=ide_we_n=1; ide_addr=0; ide_wdata=0; ide_wdata_oe=0; byte and poll counters 0. Reset mid-transfer abandons it; no further bus activity until a new command.
- Bus access (sub-module): SETUP 1 cycle (ce_n=0, addr stable), STROBE STROBE_CYCLES cycles (oe_n=0 or we_n=0), HOLD 1 cycle (strobes high, ce_n=0), then ce_n=1. Read data sampled on the last STROBE cycle. Access latency = STROBE_CYCLES+2 cycles. Strobes never overlap; addr/wdata constant for the whole access.
- Registers: 2=sector count, 3=LBA0, 4=LBA1, 5=LBA2, 7=command (write)/status (read), 0=data.
- FSM: IDLE -> (cmd_valid) latch cmd_write/cmd_lba, clear error -> SET_CNT (write 8'h01 to reg 2) -> SET_LBA0 -> SET_LBA1 -> SET_LBA2 -> SET_CMD (write 8'h20 or 8'h30 to reg 7) -> POLL -> XFER -> FINISH -> IDLE.
- POLL: read reg 7; ERR bit0=1 -> ERROR; BSY bit7=0 and DRQ bit3=1 -> XFER; otherwise repeat. POLL_TIMEOUT polls without success -> ERROR.
- XFER read: read reg 0; hold byte on rd_data with rd_valid=1 until rd_ready; the next access starts only after handshake (back-pressure stalls the bus with ce_n=1).
- XFER write: wr_ready=1 only while idle between accesses; on wr_valid&wr_ready, latch byte and write reg 0.
- Byte counter 10 bits; XFER ends after exactly SECTOR_BYTES handshakes (count 0..511, no wrap).
- FINISH: done pulse 1 cycle, cmd_ready=1 next cycle. ERROR: error=1, done pulse, -> IDLE. Any rd_valid pending is dropped.
- cmd_valid while busy is ignored (cmd_ready=0). Exactly one command in flight.

Decomposition:
- Package ide_pkg: register address constants (IDE_REG_DATA=0, IDE_REG_COUNT=2, IDE_REG_LBA0..2=3..5, IDE_REG_CMD=7), command codes (IDE_CMD_READ=8'h20, IDE_CMD_WRITE=8'h30), status bit indices (BSY=7, DRQ=3, ERR=0), FSM state enum.
- Sub-module ide_bus_cycle: executes one read/write access (start, rw, addr, wdata -> busy, rdata, rdata_valid) and owns the strobe timing.

Test Plan:
- Reset during XFER at byte 100 -> all strobes high, cmd_ready=1, error=0 the cycle after arst rises; no bus activity afterwards.
- Read cmd, lba=24'h000010, drive preloaded mem[16+i]=i[7:0] -> register writes 2<=01, 3<=10, 4<=00, 5<=00, 7<=20; 512 rd bytes 00..FF,00..FF; single done pulse, error=0.
- Write cmd, lba=24'h000200, wr_data=8'hA5^i -> 512 writes to reg 0 in order; drive mem[512..1023] matches; done, error=0.
- rd_ready held low 20 cycles at byte 5 -> rd_data stable, ide_ce_n=1 during stall, no byte lost or duplicated.
- Status stuck 8'h80, POLL_TIMEOUT=8 -> exactly 8 status reads, then error=1, done pulse, no data access.
- Status 8'h01 on first poll -> error=1 immediately; next command clears error and completes normally.
